uart_wb_master: RTL and testbench
=================================

# uart_wb_master

Byte-stream to Wishbone bus initiator: the host-side counterpart of the SoC's Wishbone peripheral responders. Parses framed read/write commands arriving from a UART receiver byte stream, runs single Wishbone cycles on the SoC bus, and returns status and read data on a UART transmitter byte stream. Used as a debug master in parallel with the CPU, through an arbiter.

## Interface
- WB_AW, 16: Wishbone word-address width; 16 max, since the frame carries 2 address bytes.
- WB_DW, 32: Wishbone data width; fixed at 32.
- BUS_TO_W, 8: bus-timeout counter width; timeout after 2^BUS_TO_W cycles without ack.
- RX_TO_W, 16: inter-byte timeout counter width.

- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- rx_data  in  8  received byte.
- rx_stb  in  1  one-cycle strobe; rx_data valid.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts the byte when tx_valid & tx_ready.
- wb_addr  out  WB_AW  word address.
- wb_wdata  out  WB_DW  write data.
- wb_wmsk  out  WB_DW/8  byte write mask.
- wb_we  out  1  write enable.
- wb_cyc  out  1  cycle request; no separate stb.
- wb_rdata  in  WB_DW  read data, valid when wb_ack.
- wb_ack  in  1  cycle acknowledge; may be combinational from wb_cyc, including same cycle.
- busy  out  1  high from the first command byte until the last response byte is accepted.

## Operation
- Frame format: CMD, ADDR_HI, ADDR_LO, then for writes D3 D2 D1 D0. All fields MSB first. Address is truncated to WB_AW bits.
- CMD[7:4] = 0x1 selects read.
- CMD[7:4] = 0x2 selects write; CMD[3:0] is wb_wmsk.
- Any other CMD: no address/data bytes are consumed; respond with 0x3F only.
- Response:
  - Status byte first: 0x5A = OK, 0xEE = bus timeout.
  - A successful read follows the status with 4 rdata bytes, MSB first.
  - Writes and timed-out reads send the status byte only.
- FSM states:
  - IDLE: rx_stb → decode CMD.
    - Valid CMD → ADDR.
    - Invalid CMD → RESP with 0x3F.
  - ADDR: collect 2 bytes. Read → BUS. Write → DATA.
  - DATA: collect 4 bytes → BUS.
  - BUS: wb_cyc=1. Start the bus-timeout counter at 0.
    - wb_ack=1 at an edge: latch wb_rdata, status 0x5A → RESP.
    - Counter reaches 2^BUS_TO_W−1 with no ack: drop cyc, status 0xEE → RESP.
  - RESP: shift out 1 or 5 bytes with valid/ready handshake → IDLE.
- In ADDR/DATA, the inter-byte counter resets on each rx_stb. On overflow (2^RX_TO_W cycles idle), the partial frame is dropped silently → IDLE, no response.
- rx_stb while in BUS or RESP: byte discarded, no side effects.
- wb_addr, wb_wdata, wb_wmsk and wb_we are stable for the whole time wb_cyc is high.
- wb_wmsk is forced to 0 for reads.

## Timing
- Reset values: wb_cyc=0, wb_we=0, wb_addr=0, wb_wdata=0, wb_wmsk=0, tx_valid=0, tx_data=0x00, busy=0, FSM=IDLE.
- wb_cyc rises on the edge after the last frame byte's rx_stb.
- wb_ack is sampled on every edge while wb_cyc=1. With ack seen at edge N:
  - wb_cyc is 0 from edge N.
  - tx_valid=1 with the status byte from edge N.
  - Same-cycle ack gives wb_cyc high for exactly 1 cycle.
- The bus is never held more than one cycle past ack.
- No back-to-back cycles: each frame gets exactly one Wishbone cycle.
- tx_valid holds with stable tx_data until tx_ready.
- The next byte is presented on the edge after acceptance. No bubble is required, but a 1-cycle bubble is allowed.
- The status byte is only ever presented after wb_cyc has fallen.
- Reset mid-operation: wb_cyc and tx_valid are 0 on the edge where rst is sampled high. The frame is discarded and no response is sent.
- Timeout length: wb_cyc high for exactly 2^BUS_TO_W cycles, then falls.

## Test plan
- Write: bytes 0x2F 0x12 0x34 0xDE 0xAD 0xBE 0xEF, ack after 3 cycles.
  - Required bus cycle: wb_addr=0x1234, wb_wdata=0xDEADBEEF, wb_wmsk=0xF, wb_we=1, cyc high 3 cycles.
  - Required response: single byte 0x5A.
- Read with combinational ack = cyc: bytes 0x10 0x00 0x08, rdata 0xCAFEF00D.
  - Required bus cycle: cyc high exactly 1 cycle, wb_we=0, wb_wmsk=0.
  - Required response: 0x5A 0xCA 0xFE 0xF0 0x0D.
- Never-acking slave, read 0x10 0x00 0x04:
  - cyc high for 256 cycles (BUS_TO_W=8).
  - Response: single 0xEE.
- Invalid CMD 0x7F:
  - Response 0x3F, no wb_cyc pulse.
  - A following valid read is handled normally.
- Partial frame 0x2F 0x12, then silence past the RX timeout (use RX_TO_W=4):
  - No bus cycle, no response.
  - A new frame afterwards is parsed from its CMD byte.
- Backpressure and reset:
  - tx_ready held low for 10 cycles during a read response: tx_data stable, no byte lost or duplicated.
  - rst asserted while wb_cyc=1: cyc is 0 on the edge after rst is sampled, and no response is sent.
- Byte injected during BUS: ignored, and the response is unchanged.

Source files
------------

// File: rtl/uart_wb_master_if.sv
// Bundle of the byte-stream and Wishbone signals of the UART debug master.
// The master modport is the bridge itself; the slave modport is its environment
// (UART receiver/transmitter and the bus responder).
interface uart_wb_master_if #(
  parameter int WB_AW = 16,
  parameter int WB_DW = 32
);
  logic [7:0]         rx_data;
  logic               rx_stb;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic [WB_AW-1:0]   wb_addr;
  logic [WB_DW-1:0]   wb_wdata;
  logic [WB_DW/8-1:0] wb_wmsk;
  logic               wb_we;
  logic               wb_cyc;
  logic [WB_DW-1:0]   wb_rdata;
  logic               wb_ack;
  logic               busy;

  modport master (
    input  rx_data, rx_stb, tx_ready, wb_rdata, wb_ack,
    output tx_data, tx_valid, wb_addr, wb_wdata, wb_wmsk, wb_we, wb_cyc, busy
  );

  modport slave (
    output rx_data, rx_stb, tx_ready, wb_rdata, wb_ack,
    input  tx_data, tx_valid, wb_addr, wb_wdata, wb_wmsk, wb_we, wb_cyc, busy
  );
endinterface

// File: rtl/uart_wb_master.sv
// UART byte-stream to Wishbone initiator: parses CMD/ADDR/DATA frames, runs one
// Wishbone cycle per frame and returns a status byte (plus read data).
module uart_wb_master #(
  parameter int WB_AW    = 16,
  parameter int WB_DW    = 32,
  parameter int BUS_TO_W = 8,
  parameter int RX_TO_W  = 16
) (
  input logic              clk,
  input logic              rst,
  uart_wb_master_if.master io
);

  localparam logic [3:0] CMD_RD = 4'h1;
  localparam logic [3:0] CMD_WR = 4'h2;
  localparam logic [7:0] ST_OK  = 8'h5A;
  localparam logic [7:0] ST_TO  = 8'hEE;
  localparam logic [7:0] ST_BAD = 8'h3F;
  localparam logic [RX_TO_W-1:0]  RX_ONE  = 1;
  localparam logic [BUS_TO_W-1:0] BUS_ONE = 1;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

  state_t                state, state_next;
  logic [15:0]           addr_buf;
  logic [WB_DW-1:0]      wdata;
  logic [WB_DW/8-1:0]    wmsk;
  logic                  we;
  logic [1:0]            byte_cnt;
  logic [RX_TO_W-1:0]    rx_cnt;
  logic [BUS_TO_W-1:0]   bus_cnt;
  logic [WB_DW+7:0]      resp_sr;
  logic [2:0]            resp_left;
  logic                  cmd_ok;
  logic                  rx_timeout;
  logic                  bus_timeout;

  assign cmd_ok      = (io.rx_data[7:4] == CMD_RD) || (io.rx_data[7:4] == CMD_WR);
  assign rx_timeout  = !io.rx_stb && (rx_cnt == '1);
  assign bus_timeout = !io.wb_ack && (bus_cnt == '1);

  // Register fields are only loaded while collecting a frame, so they stay
  // stable for the whole bus cycle.
  assign io.wb_addr  = addr_buf[WB_AW-1:0];
  assign io.wb_wdata = wdata;
  assign io.wb_wmsk  = wmsk;
  assign io.wb_we    = we;
  assign io.tx_data  = resp_sr[WB_DW+7 -: 8];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state decode and state-derived handshake outputs.
  always_comb begin
    state_next  = state;
    io.wb_cyc   = 1'b0;
    io.tx_valid = 1'b0;
    io.busy     = 1'b1;
    case (state)
      S_IDLE: begin
        io.busy = 1'b0;
        if (io.rx_stb) state_next = cmd_ok ? S_ADDR : S_RESP;
      end
      S_ADDR: begin
        if (io.rx_stb && byte_cnt == 2'd1) state_next = we ? S_DATA : S_BUS;
        else if (rx_timeout)               state_next = S_IDLE;
      end
      S_DATA: begin
        if (io.rx_stb && byte_cnt == 2'd3) state_next = S_BUS;
        else if (rx_timeout)               state_next = S_IDLE;
      end
      S_BUS: begin
        io.wb_cyc = 1'b1;
        if (io.wb_ack || bus_timeout) state_next = S_RESP;
      end
      S_RESP: begin
        io.tx_valid = 1'b1;
        if (io.tx_ready && resp_left == 3'd0) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Frame capture, timeout counters and response shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_buf  <= '0;
      wdata     <= '0;
      wmsk      <= '0;
      we        <= 1'b0;
      byte_cnt  <= '0;
      rx_cnt    <= '0;
      bus_cnt   <= '0;
      resp_sr   <= '0;
      resp_left <= '0;
    end else begin
      bus_cnt <= '0;
      case (state)
        S_IDLE: begin
          if (io.rx_stb) begin
            byte_cnt <= '0;
            rx_cnt   <= '0;
            we       <= (io.rx_data[7:4] == CMD_WR);
            wmsk     <= (io.rx_data[7:4] == CMD_WR) ? io.rx_data[3:0] : '0;
            if (!cmd_ok) begin
              resp_sr   <= {ST_BAD, {WB_DW{1'b0}}};
              resp_left <= 3'd0;
            end
          end
        end
        S_ADDR, S_DATA: begin
          if (io.rx_stb) begin
            rx_cnt <= '0;
            if (state == S_ADDR) begin
              addr_buf <= {addr_buf[7:0], io.rx_data};
              byte_cnt <= (byte_cnt == 2'd1) ? 2'd0 : byte_cnt + 2'd1;
            end else begin
              wdata    <= {wdata[WB_DW-9:0], io.rx_data};
              byte_cnt <= byte_cnt + 2'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + RX_ONE;
          end
        end
        S_BUS: begin
          if (io.wb_ack) begin
            resp_sr   <= {ST_OK, we ? {WB_DW{1'b0}} : io.wb_rdata};
            resp_left <= we ? 3'd0 : 3'd4;
          end else if (bus_timeout) begin
            resp_sr   <= {ST_TO, {WB_DW{1'b0}}};
            resp_left <= 3'd0;
          end else begin
            bus_cnt <= bus_cnt + BUS_ONE;
          end
        end
        S_RESP: begin
          if (io.tx_ready) begin
            resp_sr <= {resp_sr[WB_DW-1:0], 8'h00};
            if (resp_left != 3'd0) resp_left <= resp_left - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_master.sv
// Self-checking bench for uart_wb_master: scripted frames, a configurable bus
// responder, and queues of expected bus cycles / response bytes.
module tb_uart_wb_master;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmsk;
    logic        we;
    logic [15:0] len;
  } bus_rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  int   ack_delay = 0;
  bit   ack_en = 1'b1;
  int   cyc_cnt = 0;

  bus_rec_t    bus_obs[$], bus_exp[$];
  logic [7:0]  tx_obs[$], tx_exp[$];
  int          stab_err = 0, hold_err = 0, overlap_err = 0;

  uart_wb_master_if #(.WB_AW(16), .WB_DW(32)) io ();

  uart_wb_master #(.WB_AW(16), .WB_DW(32), .BUS_TO_W(8), .RX_TO_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  always #5 clk = ~clk;

  // Bus responder: ack after ack_delay cycles of cyc (0 = combinational ack).
  always_ff @(posedge clk) cyc_cnt <= io.wb_cyc ? cyc_cnt + 1 : 0;
  assign io.wb_ack = io.wb_cyc && ack_en && (cyc_cnt >= ack_delay);

  // Monitor sampling on the falling edge.
  initial begin
    bus_rec_t   cur;
    int         cur_len;
    logic       prev_valid, prev_ready;
    logic [7:0] prev_data;
    cur = '0; cur_len = 0; prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (io.wb_cyc) begin
        if (cur_len == 0) begin
          cur.addr = io.wb_addr; cur.wdata = io.wb_wdata;
          cur.wmsk = io.wb_wmsk; cur.we = io.wb_we;
        end else if (io.wb_addr !== cur.addr || io.wb_wdata !== cur.wdata ||
                     io.wb_wmsk !== cur.wmsk || io.wb_we !== cur.we) begin
          stab_err++;
        end
        cur_len++;
      end else if (cur_len != 0) begin
        cur.len = 16'(cur_len);
        if (!cur.we) cur.wdata = '0;
        bus_obs.push_back(cur);
        cur_len = 0;
      end
      if (io.tx_valid && io.wb_cyc) overlap_err++;
      if (!rst && prev_valid && !prev_ready && (!io.tx_valid || io.tx_data !== prev_data))
        hold_err++;
      if (io.tx_valid && io.tx_ready) tx_obs.push_back(io.tx_data);
      prev_valid = io.tx_valid; prev_ready = io.tx_ready; prev_data = io.tx_data;
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  function automatic bus_rec_t mk_rec(input logic [15:0] a, input logic [31:0] d,
                                      input logic [3:0] m, input logic w, input int n);
    bus_rec_t r;
    r.addr = a; r.wdata = d; r.wmsk = m; r.we = w; r.len = 16'(n);
    return r;
  endfunction

  // All stimulus tasks start and end at posedge+1.
  task automatic send_byte(input logic [7:0] b);
    io.rx_data = b;
    io.rx_stb  = 1'b1;
    @(posedge clk); #1;
    io.rx_stb  = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    for (int i = 0; i < limit; i++) begin
      if (!io.busy) break;
      @(posedge clk); #1;
    end
    ok = !io.busy;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (io.wb_cyc !== 1'b0) begin errors++; $display("FAIL reset_cyc got %b required 0", io.wb_cyc); end
    checks++; if (io.wb_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b required 0", io.wb_we); end
    checks++; if (io.wb_addr !== 16'h0) begin errors++; $display("FAIL reset_addr got %h required 0000", io.wb_addr); end
    checks++; if (io.wb_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h required 0", io.wb_wdata); end
    checks++; if (io.wb_wmsk !== 4'h0) begin errors++; $display("FAIL reset_wmsk got %h required 0", io.wb_wmsk); end
    checks++; if (io.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b required 0", io.tx_valid); end
    checks++; if (io.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h required 00", io.tx_data); end
    checks++; if (io.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", io.busy); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write;
    bus_rec_t eb, ob; logic [7:0] et, ot; bit ok;
    ack_en = 1'b1; ack_delay = 2;
    bus_exp.push_back(mk_rec(16'h1234, 32'hDEADBEEF, 4'hF, 1'b1, 3));
    tx_exp.push_back(8'h5A);
    send_byte(8'h2F); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    checks++; if (io.wb_cyc !== 1'b1) begin errors++; $display("FAIL write_cyc_rise got %b required 1", io.wb_cyc); end
    wait_idle(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL write_idle busy got 1 required 0"); end
    while (bus_exp.size() > 0) begin
      eb = bus_exp.pop_front(); checks++;
      if (bus_obs.size() == 0) begin errors++; $display("FAIL write_bus got none required %h", eb); end
      else begin ob = bus_obs.pop_front();
        if (ob !== eb) begin errors++; $display("FAIL write_bus got %h required %h", ob, eb); end end
    end
    checks++; if (bus_obs.size() != 0) begin errors++; $display("FAIL write_bus_extra got %0d required 0", bus_obs.size()); bus_obs.delete(); end
    while (tx_exp.size() > 0) begin
      et = tx_exp.pop_front(); checks++;
      if (tx_obs.size() == 0) begin errors++; $display("FAIL write_tx got none required %h", et); end
      else begin ot = tx_obs.pop_front();
        if (ot !== et) begin errors++; $display("FAIL write_tx got %h required %h", ot, et); end end
    end
    checks++; if (tx_obs.size() != 0) begin errors++; $display("FAIL write_tx_extra got %0d required 0", tx_obs.size()); tx_obs.delete(); end
  endtask

  task automatic test_read_comb;
    bus_rec_t eb, ob; logic [7:0] et, ot; bit ok;
    ack_en = 1'b1; ack_delay = 0; io.wb_rdata = 32'hCAFEF00D;
    bus_exp.push_back(mk_rec(16'h0008, 32'h0, 4'h0, 1'b0, 1));
    tx_exp.push_back(8'h5A); tx_exp.push_back(8'hCA); tx_exp.push_back(8'hFE);
    tx_exp.push_back(8'hF0); tx_exp.push_back(8'h0D);
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h08);
    wait_idle(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL read_idle busy got 1 required 0"); end
    while (bus_exp.size() > 0) begin
      eb = bus_exp.pop_front(); checks++;
      if (bus_obs.size() == 0) begin errors++; $display("FAIL read_bus got none required %h", eb); end
      else begin ob = bus_obs.pop_front();
        if (ob !== eb) begin errors++; $display("FAIL read_bus got %h required %h", ob, eb); end end
    end
    checks++; if (bus_obs.size() != 0) begin errors++; $display("FAIL read_bus_extra got %0d required 0", bus_obs.size()); bus_obs.delete(); end
    while (tx_exp.size() > 0) begin
      et = tx_exp.pop_front(); checks++;
      if (tx_obs.size() == 0) begin errors++; $display("FAIL read_tx got none required %h", et); end
      else begin ot = tx_obs.pop_front();
        if (ot !== et) begin errors++; $display("FAIL read_tx got %h required %h", ot, et); end end
    end
    checks++; if (tx_obs.size() != 0) begin errors++; $display("FAIL read_tx_extra got %0d required 0", tx_obs.size()); tx_obs.delete(); end
  endtask

  task automatic test_bus_timeout;
    bus_rec_t eb, ob; logic [7:0] et, ot; bit ok;
    ack_en = 1'b0;
    bus_exp.push_back(mk_rec(16'h0004, 32'h0, 4'h0, 1'b0, 256));
    tx_exp.push_back(8'hEE);
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h04);
    wait_idle(400, ok);
    ack_en = 1'b1;
    checks++; if (!ok) begin errors++; $display("FAIL timeout_idle busy got 1 required 0"); end
    while (bus_exp.size() > 0) begin
      eb = bus_exp.pop_front(); checks++;
      if (bus_obs.size() == 0) begin errors++; $display("FAIL timeout_bus got none required %h", eb); end
      else begin ob = bus_obs.pop_front();
        if (ob !== eb) begin errors++; $display("FAIL timeout_bus got %h required %h", ob, eb); end end
    end
    checks++; if (bus_obs.size() != 0) begin errors++; $display("FAIL timeout_bus_extra got %0d required 0", bus_obs.size()); bus_obs.delete(); end
    while (tx_exp.size() > 0) begin
      et = tx_exp.pop_front(); checks++;
      if (tx_obs.size() == 0) begin errors++; $display("FAIL timeout_tx got none required %h", et); end
      else begin ot = tx_obs.pop_front();
        if (ot !== et) begin errors++; $display("FAIL timeout_tx got %h required %h", ot, et); end end
    end
    checks++; if (tx_obs.size() != 0) begin errors++; $display("FAIL timeout_tx_extra got %0d required 0", tx_obs.size()); tx_obs.delete(); end
  endtask

  task automatic test_invalid_cmd;
    bus_rec_t eb, ob; logic [7:0] et, ot; bit ok;
    tx_exp.push_back(8'h3F);
    send_byte(8'h7F);
    wait_idle(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL invalid_idle busy got 1 required 0"); end
    checks++; if (bus_obs.size() != 0) begin errors++; $display("FAIL invalid_no_cyc got %0d cycles required 0", bus_obs.size()); bus_obs.delete(); end
    ack_delay = 1; io.wb_rdata = 32'h01234567;
    bus_exp.push_back(mk_rec(16'h0008, 32'h0, 4'h0, 1'b0, 2));
    tx_exp.push_back(8'h5A); tx_exp.push_back(8'h01); tx_exp.push_back(8'h23);
    tx_exp.push_back(8'h45); tx_exp.push_back(8'h67);
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h08);
    wait_idle(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL invalid_follow_idle busy got 1 required 0"); end
    while (bus_exp.size() > 0) begin
      eb = bus_exp.pop_front(); checks++;
      if (bus_obs.size() == 0) begin errors++; $display("FAIL invalid_follow_bus got none required %h", eb); end
      else begin ob = bus_obs.pop_front();
        if (ob !== eb) begin errors++; $display("FAIL invalid_follow_bus got %h required %h", ob, eb); end end
    end
    while (tx_exp.size() > 0) begin
      et = tx_exp.pop_front(); checks++;
      if (tx_obs.size() == 0) begin errors++; $display("FAIL invalid_tx got none required %h", et); end
      else begin ot = tx_obs.pop_front();
        if (ot !== et) begin errors++; $display("FAIL invalid_tx got %h required %h", ot, et); end end
    end
    checks++; if (tx_obs.size() != 0) begin errors++; $display("FAIL invalid_tx_extra got %0d required 0", tx_obs.size()); tx_obs.delete(); end
  endtask

  task automatic test_rx_timeout;
    bus_rec_t eb, ob; logic [7:0] et, ot; bit ok;
    send_byte(8'h2F); send_byte(8'h12);
    checks++; if (io.busy !== 1'b1) begin errors++; $display("FAIL rxto_busy_partial got %b required 1", io.busy); end
    wait_idle(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rxto_drop busy got 1 required 0"); end
    repeat (5) begin @(posedge clk); #1; end
    checks++; if (bus_obs.size() != 0 || tx_obs.size() != 0) begin
      errors++; $display("FAIL rxto_silent got %0d cycles %0d bytes required 0 0", bus_obs.size(), tx_obs.size());
      bus_obs.delete(); tx_obs.delete(); end
    ack_delay = 1;
    bus_exp.push_back(mk_rec(16'hABCD, 32'h01020304, 4'h1, 1'b1, 2));
    tx_exp.push_back(8'h5A);
    send_byte(8'h21); send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    wait_idle(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rxto_next_idle busy got 1 required 0"); end
    while (bus_exp.size() > 0) begin
      eb = bus_exp.pop_front(); checks++;
      if (bus_obs.size() == 0) begin errors++; $display("FAIL rxto_next_bus got none required %h", eb); end
      else begin ob = bus_obs.pop_front();
        if (ob !== eb) begin errors++; $display("FAIL rxto_next_bus got %h required %h", ob, eb); end end
    end
    while (tx_exp.size() > 0) begin
      et = tx_exp.pop_front(); checks++;
      if (tx_obs.size() == 0) begin errors++; $display("FAIL rxto_next_tx got none required %h", et); end
      else begin ot = tx_obs.pop_front();
        if (ot !== et) begin errors++; $display("FAIL rxto_next_tx got %h required %h", ot, et); end end
    end
  endtask

  task automatic test_backpressure;
    bus_rec_t eb, ob; logic [7:0] et, ot; bit ok;
    ack_delay = 0; io.wb_rdata = 32'hA1B2C3D4; io.tx_ready = 1'b0;
    bus_exp.push_back(mk_rec(16'h0010, 32'h0, 4'h0, 1'b0, 1));
    tx_exp.push_back(8'h5A); tx_exp.push_back(8'hA1); tx_exp.push_back(8'hB2);
    tx_exp.push_back(8'hC3); tx_exp.push_back(8'hD4);
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h10);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (io.tx_valid) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL bp_valid got 0 required 1"); end
    repeat (10) begin @(posedge clk); #1; end
    io.tx_ready = 1'b1;
    @(posedge clk); #1;
    io.tx_ready = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    checks++; if (io.tx_data !== 8'hA1) begin errors++; $display("FAIL bp_hold_data got %h required a1", io.tx_data); end
    io.tx_ready = 1'b1;
    wait_idle(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_idle busy got 1 required 0"); end
    while (bus_exp.size() > 0) begin
      eb = bus_exp.pop_front(); checks++;
      if (bus_obs.size() == 0) begin errors++; $display("FAIL bp_bus got none required %h", eb); end
      else begin ob = bus_obs.pop_front();
        if (ob !== eb) begin errors++; $display("FAIL bp_bus got %h required %h", ob, eb); end end
    end
    while (tx_exp.size() > 0) begin
      et = tx_exp.pop_front(); checks++;
      if (tx_obs.size() == 0) begin errors++; $display("FAIL bp_tx got none required %h", et); end
      else begin ot = tx_obs.pop_front();
        if (ot !== et) begin errors++; $display("FAIL bp_tx got %h required %h", ot, et); end end
    end
    checks++; if (tx_obs.size() != 0) begin errors++; $display("FAIL bp_tx_extra got %0d required 0", tx_obs.size()); tx_obs.delete(); end
  endtask

  task automatic test_reset_mid_cycle;
    ack_en = 1'b0;
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h04);
    repeat (5) begin @(posedge clk); #1; end
    checks++; if (io.wb_cyc !== 1'b1) begin errors++; $display("FAIL rstmid_pre_cyc got %b required 1", io.wb_cyc); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (io.wb_cyc !== 1'b0) begin errors++; $display("FAIL rstmid_cyc got %b required 0", io.wb_cyc); end
    checks++; if (io.tx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_tx_valid got %b required 0", io.tx_valid); end
    rst = 1'b0;
    ack_en = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    checks++; if (tx_obs.size() != 0 || io.busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_no_resp got %0d bytes busy %b required 0 bytes busy 0", tx_obs.size(), io.busy);
      tx_obs.delete(); end
    bus_obs.delete();
  endtask

  task automatic test_inject_during_bus;
    bus_rec_t eb, ob; logic [7:0] et, ot; bit ok;
    ack_delay = 5; io.wb_rdata = 32'h5566AA77;
    bus_exp.push_back(mk_rec(16'h000C, 32'h0, 4'h0, 1'b0, 6));
    tx_exp.push_back(8'h5A); tx_exp.push_back(8'h55); tx_exp.push_back(8'h66);
    tx_exp.push_back(8'hAA); tx_exp.push_back(8'h77);
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h0C);
    @(posedge clk); #1;
    send_byte(8'h2F);
    wait_idle(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL inject_idle busy got 1 required 0"); end
    while (bus_exp.size() > 0) begin
      eb = bus_exp.pop_front(); checks++;
      if (bus_obs.size() == 0) begin errors++; $display("FAIL inject_bus got none required %h", eb); end
      else begin ob = bus_obs.pop_front();
        if (ob !== eb) begin errors++; $display("FAIL inject_bus got %h required %h", ob, eb); end end
    end
    while (tx_exp.size() > 0) begin
      et = tx_exp.pop_front(); checks++;
      if (tx_obs.size() == 0) begin errors++; $display("FAIL inject_tx got none required %h", et); end
      else begin ot = tx_obs.pop_front();
        if (ot !== et) begin errors++; $display("FAIL inject_tx got %h required %h", ot, et); end end
    end
    checks++; if (tx_obs.size() != 0) begin errors++; $display("FAIL inject_tx_extra got %0d required 0", tx_obs.size()); tx_obs.delete(); end
  endtask

  task automatic test_invariants;
    checks++; if (stab_err != 0) begin errors++; $display("FAIL bus_stable got %0d changes required 0", stab_err); end
    checks++; if (hold_err != 0) begin errors++; $display("FAIL tx_hold got %0d changes required 0", hold_err); end
    checks++; if (overlap_err != 0) begin errors++; $display("FAIL tx_during_cyc got %0d cycles required 0", overlap_err); end
  endtask

  initial begin
    io.rx_data  = 8'h00;
    io.rx_stb   = 1'b0;
    io.tx_ready = 1'b1;
    io.wb_rdata = 32'h0;
    test_reset;
    test_write;
    test_read_comb;
    test_bus_timeout;
    test_invalid_cmd;
    test_rx_timeout;
    test_backpressure;
    test_reset_mid_cycle;
    test_inject_during_bus;
    test_invariants;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
